// File: rtl/pdp8_iot_master_if.sv
// PDP-8 I/O bus between the CPU-side IOT initiator and the device side.
// The master drives the IOT phase, instruction, select and AC lines.
interface pdp8_iot_master_if;
   logic        iot;
   logic [3:0]  state;
   logic [11:0] mb;
   logic [5:0]  io_select;
   logic [11:0] io_data_in;
   logic [11:0] io_data_out;
   logic        io_data_avail;
   logic        io_skip;
   logic        io_clear_ac;
   logic        io_interrupt;

   modport master (
      output iot, state, mb, io_select, io_data_in,
      input  io_data_out, io_data_avail, io_skip,
      input  io_clear_ac, io_interrupt
   );

   modport slave (
      input  iot, state, mb, io_select, io_data_in,
      output io_data_out, io_data_avail, io_skip,
      output io_clear_ac, io_interrupt
   );
endinterface

// File: rtl/pdp8_iot_master.sv
// PDP-8 IOT sequencer: runs one IOT per start, merges device responses,
// and owns the interrupt enable (ION/IOF/SKON) with the ION delay.
module pdp8_iot_master (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [11:0] ir,
   input  logic [11:0] ac_in,
   input  logic        instr_done,
   input  logic        int_ack,
   pdp8_iot_master_if.master bus,
   output logic        busy,
   output logic        done,
   output logic [11:0] ac_out,
   output logic        ac_load,
   output logic        skip,
   output logic        ion,
   output logic        int_req
);

   typedef enum logic [3:0] {
      S_IDLE = 4'h0,
      S_F0   = 4'h1,
      S_F1   = 4'h2,
      S_F2   = 4'h3,
      S_F3   = 4'h4
   } state_e;

   state_e      state_q, state_d;
   logic [11:0] mb_q, mb_d;
   logic [5:0]  sel_q, sel_d;
   logic [11:0] din_q, din_d;
   logic        skp_r_q, skp_r_d;
   logic        clr_r_q, clr_r_d;
   logic        avl_r_q, avl_r_d;
   logic [11:0] dat_r_q, dat_r_d;
   logic        done_q, done_d;
   logic [11:0] ac_out_q, ac_out_d;
   logic        ac_load_q, ac_load_d;
   logic        skip_q, skip_d;
   logic        ion_q, ion_d;
   logic        pend_q, pend_d;
   logic        io_int_q, io_int_d;
   logic        int_req_q, int_req_d;
   logic        accept;

   always_comb begin
      state_d   = state_q;
      mb_d      = mb_q;
      sel_d     = sel_q;
      din_d     = din_q;
      skp_r_d   = skp_r_q;
      clr_r_d   = clr_r_q;
      avl_r_d   = avl_r_q;
      dat_r_d   = dat_r_q;
      done_d    = 1'b0;
      ac_out_d  = 12'o0000;
      ac_load_d = 1'b0;
      skip_d    = 1'b0;
      ion_d     = ion_q;
      pend_d    = pend_q;
      io_int_d  = bus.io_interrupt;
      int_req_d = ion_q & io_int_q;
      accept    = (state_q == S_IDLE) && start
                  && (ir[11:9] == 3'b110);

      // The ION instruction's own instr_done lands in its done cycle
      if (instr_done && pend_q && !done_q) begin
         ion_d  = 1'b1;
         pend_d = 1'b0;
      end

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               mb_d  = ir;
               sel_d = ir[8:3];
               din_d = ac_in;
               if (ir[8:3] != 6'o00) begin
                  state_d = S_F0;
               end else begin
                  done_d = 1'b1;
                  case (ir[2:0])
                     3'd0: begin
                        skip_d = ion_q;
                        ion_d  = 1'b0;
                        pend_d = 1'b0;
                     end
                     3'd1: pend_d = 1'b1;
                     3'd2: begin
                        ion_d  = 1'b0;
                        pend_d = 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
         end
         S_F0: state_d = S_F1;
         S_F1: state_d = S_F2;
         S_F2: begin
            skp_r_d = bus.io_skip;
            clr_r_d = bus.io_clear_ac;
            avl_r_d = bus.io_data_avail;
            dat_r_d = bus.io_data_out;
            state_d = S_F3;
         end
         S_F3: begin
            done_d    = 1'b1;
            ac_out_d  = (clr_r_q ? 12'o0000 : din_q)
                        | (avl_r_q ? dat_r_q : 12'o0000);
            ac_load_d = clr_r_q | avl_r_q;
            skip_d    = skp_r_q;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (int_ack) begin
         ion_d  = 1'b0;
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         mb_q      <= 12'o0000;
         sel_q     <= 6'o00;
         din_q     <= 12'o0000;
         skp_r_q   <= 1'b0;
         clr_r_q   <= 1'b0;
         avl_r_q   <= 1'b0;
         dat_r_q   <= 12'o0000;
         done_q    <= 1'b0;
         ac_out_q  <= 12'o0000;
         ac_load_q <= 1'b0;
         skip_q    <= 1'b0;
         ion_q     <= 1'b0;
         pend_q    <= 1'b0;
         io_int_q  <= 1'b0;
         int_req_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mb_q      <= mb_d;
         sel_q     <= sel_d;
         din_q     <= din_d;
         skp_r_q   <= skp_r_d;
         clr_r_q   <= clr_r_d;
         avl_r_q   <= avl_r_d;
         dat_r_q   <= dat_r_d;
         done_q    <= done_d;
         ac_out_q  <= ac_out_d;
         ac_load_q <= ac_load_d;
         skip_q    <= skip_d;
         ion_q     <= ion_d;
         pend_q    <= pend_d;
         io_int_q  <= io_int_d;
         int_req_q <= int_req_d;
      end
   end

   assign bus.iot        = (state_q != S_IDLE);
   assign bus.state      = state_q;
   assign bus.mb         = mb_q;
   assign bus.io_select  = sel_q;
   assign bus.io_data_in = din_q;
   assign busy           = (state_q != S_IDLE);
   assign done           = done_q;
   assign ac_out         = ac_out_q;
   assign ac_load        = ac_load_q;
   assign skip           = skip_q;
   assign ion            = ion_q;
   assign int_req        = int_req_q;

endmodule

// File: tb/tb_pdp8_iot_master.sv
// Directed bench for pdp8_iot_master: device IOTs, ION/IOF/SKON,
// interrupt request timing, ignored starts and mid-sequence reset.
module tb_pdp8_iot_master;
   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [11:0] ir;
   logic [11:0] ac_in;
   logic        instr_done;
   logic        int_ack;
   logic        busy, done, ac_load, skip, ion, int_req;
   logic [11:0] ac_out;
   int          total = 0;
   int          bad = 0;
   int          ndone;

   pdp8_iot_master_if bus ();

   pdp8_iot_master dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .ir         (ir),
      .ac_in      (ac_in),
      .instr_done (instr_done),
      .int_ack    (int_ack),
      .bus        (bus.master),
      .busy       (busy),
      .done       (done),
      .ac_out     (ac_out),
      .ac_load    (ac_load),
      .skip       (skip),
      .ion        (ion),
      .int_req    (int_req)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [11:0] obs,
                      input logic [11:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic dev_iot(input string tg, input logic [11:0] i,
                          input logic [11:0] a, input logic c,
                          input logic v, input logic [11:0] d,
                          input logic s, input logic [11:0] eac,
                          input logic el, input logic es);
      ir = i; ac_in = a; start = 1'b1;
      step(); start = 1'b0;
      chk({tg, ".f0"}, {7'd0, bus.iot, bus.state}, 12'o0021);
      chk({tg, ".sel"}, {6'd0, bus.io_select}, {6'd0, i[8:3]});
      step();
      chk({tg, ".f1"}, {8'd0, bus.state}, 12'd2);
      step();
      chk({tg, ".f2"}, {8'd0, bus.state}, 12'd3);
      bus.io_clear_ac = c; bus.io_data_avail = v;
      bus.io_data_out = d; bus.io_skip = s;
      step();
      bus.io_clear_ac = 1'b0; bus.io_data_avail = 1'b0;
      bus.io_data_out = 12'o7777; bus.io_skip = 1'b0;
      chk({tg, ".f3"}, {7'd0, busy, bus.state}, 12'o0024);
      chk({tg, ".pre"}, {10'd0, done, ac_load}, 12'd0);
      step();
      chk({tg, ".done"}, {7'd0, done, busy, ac_load, skip, bus.iot},
          {7'd0, 1'b1, 1'b0, el, es, 1'b0});
      chk({tg, ".ac"}, ac_out, eac);
      step();
      chk({tg, ".post"}, {ac_out[10:0], done}, 12'd0);
   endtask

   task automatic int_iot(input logic [11:0] i);
      ir = i; ac_in = 12'o1234; start = 1'b1;
      step(); start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; ir = 12'o0; ac_in = 12'o0;
      instr_done = 1'b0; int_ack = 1'b0;
      bus.io_data_out = 12'o0; bus.io_data_avail = 1'b0;
      bus.io_skip = 1'b0; bus.io_clear_ac = 1'b0;
      bus.io_interrupt = 1'b0;
      step(); step();
      chk("rst.ctl", {4'd0, bus.iot, busy, done, ac_load, skip,
          ion, int_req, 1'b0}, 12'd0);
      chk("rst.state", {8'd0, bus.state}, 12'd0);
      chk("rst.mb", bus.mb, 12'o0);
      chk("rst.din", bus.io_data_in, 12'o0);
      chk("rst.acout", ac_out, 12'o0);
      reset = 1'b0;
      step();

      // TLS: no device response
      dev_iot("tls", 12'o6046, 12'o0101, 1'b0, 1'b0, 12'o0,
              1'b0, 12'o0101, 1'b0, 1'b0);
      chk("tls.mb", bus.mb, 12'o6046);
      chk("tls.din", bus.io_data_in, 12'o0101);
      chk("tls.sel", {6'd0, bus.io_select}, 12'o0004);

      dev_iot("krb", 12'o6036, 12'o0777, 1'b1, 1'b1, 12'o0215,
              1'b0, 12'o0215, 1'b1, 1'b0);
      dev_iot("krs", 12'o6034, 12'o0100, 1'b0, 1'b1, 12'o0215,
              1'b0, 12'o0315, 1'b1, 1'b0);
      dev_iot("ksf", 12'o6031, 12'o0100, 1'b0, 1'b0, 12'o0215,
              1'b1, 12'o0100, 1'b0, 1'b1);

      // ION with delayed enable
      int_iot(12'o6001);
      chk("ion.done", {9'd0, done, ac_load, ion}, 12'o0004);
      instr_done = 1'b1;
      step(); instr_done = 1'b0;
      chk("ion.own", {11'd0, ion}, 12'd0);
      step();
      instr_done = 1'b1;
      step(); instr_done = 1'b0;
      chk("ion.next", {11'd0, ion}, 12'd1);

      bus.io_interrupt = 1'b1;
      step();
      chk("irq.lag1", {11'd0, int_req}, 12'd0);
      step();
      chk("irq.lag2", {11'd0, int_req}, 12'd1);
      int_ack = 1'b1;
      step(); int_ack = 1'b0;
      chk("ack.ion", {11'd0, ion}, 12'd0);
      step();
      chk("ack.req", {11'd0, int_req}, 12'd0);
      bus.io_interrupt = 1'b0;

      // SKON with ion set
      int_iot(12'o6001);
      instr_done = 1'b1; step(); instr_done = 1'b0;
      instr_done = 1'b1; step(); instr_done = 1'b0;
      chk("skon.pre", {11'd0, ion}, 12'd1);
      int_iot(12'o6000);
      chk("skon", {9'd0, done, skip, ion}, 12'o0006);
      chk("skon.ac", {11'd0, ac_load}, 12'd0);
      int_iot(12'o6000);
      chk("skon.off", {9'd0, done, skip, ion}, 12'o0004);

      // IOF
      int_iot(12'o6001);
      instr_done = 1'b1; step(); instr_done = 1'b0;
      instr_done = 1'b1; step(); instr_done = 1'b0;
      chk("iof.pre", {11'd0, ion}, 12'd1);
      int_iot(12'o6002);
      chk("iof", {10'd0, done, ion}, 12'o0002);

      // ION then IOF before the next instr_done
      int_iot(12'o6001);
      step();
      int_iot(12'o6002);
      instr_done = 1'b1; step(); instr_done = 1'b0;
      step();
      chk("ioniof", {11'd0, ion}, 12'd0);

      // start during F1 ignored
      ndone = 0;
      ir = 12'o6046; start = 1'b1;
      step(); start = 1'b0;
      step();
      chk("busy.f1", {8'd0, bus.state}, 12'd2);
      start = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step(); start = 1'b0;
         if (done) ndone++;
      end
      chk("busy.ign", ndone[11:0], 12'd1);

      // reset in F2
      ndone = 0;
      ir = 12'o6046; start = 1'b1;
      step(); start = 1'b0;
      step(); step();
      chk("rst.f2", {8'd0, bus.state}, 12'd3);
      reset = 1'b1;
      step(); reset = 1'b0;
      chk("rst.mid", {7'd0, bus.iot, bus.state}, 12'd0);
      chk("rst.ion", {11'd0, ion}, 12'd0);
      for (int k = 0; k < 6; k++) begin
         step();
         if (done) ndone++;
      end
      chk("rst.nodone", ndone[11:0], 12'd0);

      // non-IOT instruction
      ndone = 0;
      ir = 12'o7200; start = 1'b1;
      step(); start = 1'b0;
      chk("opr.idle", {7'd0, busy, bus.iot, bus.state[2:0]}, 12'd0);
      for (int k = 0; k < 6; k++) begin
         if (done) ndone++;
         step();
      end
      chk("opr.nodone", ndone[11:0], 12'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pdp8_iot_master.md
# pdp8_iot_master

CPU-side initiator for the PDP-8 I/O bus: it drives the IOT/state/mb/io_select/io_data_in lines that the device aggregator and its peripherals (KW clock, TT console, RF disk) respond to. It executes one IOT instruction per request, samples the device responses, and returns the merged AC, skip decision and completion strobe to the CPU sequencer. It also owns the interrupt-enable flip-flop (ION/IOF/SKON, device 00), including the one-instruction ION delay and generation of the interrupt request.

## Interface
- No parameters.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse: execute IOT in `ir`
- ir  in  12  instruction word, stable on `start`
- ac_in  in  12  accumulator value, stable on `start`
- instr_done  in  1  one-cycle pulse from CPU at the end of every instruction
- int_ack  in  1  CPU has entered the interrupt (PC→0)
- io_data_out  in  12  device read data
- io_data_avail  in  1  device drives io_data_out
- io_skip  in  1  device skip condition
- io_clear_ac  in  1  device requests AC clear
- io_interrupt  in  1  OR of device interrupt requests
- iot  out  1  IOT in progress
- state  out  4  bus phase code
- mb  out  12  instruction word to devices
- io_select  out  6  device code, ir[8:3]
- io_data_in  out  12  AC value to devices
- busy  out  1  sequence active
- done  out  1  one-cycle completion pulse
- ac_out  out  12  new AC, valid with `done`
- ac_load  out  1  with `done`: CPU loads ac_out
- skip  out  1  with `done`: CPU increments PC
- ion  out  1  interrupt enable flip-flop
- int_req  out  1  interrupt request to CPU

## Operation
- Phase codes on `state`: IDLE=4'h0, F0=4'h1, F1=4'h2, F2=4'h3, F3=4'h4. No other values are driven.
- `start` is accepted only when idle and ir[11:9]=3'b110; otherwise it is ignored (no `done`).
- Accept: latch ir into mb, ir[8:3] into io_select, ac_in into io_data_in; all three are held until the next accepted start.
- io_select≠0 (device IOT): FSM IDLE→F0→F1→F2→F3→IDLE, one cycle each; iot=1 and busy=1 in F0..F3.
  - In F2, register io_skip, io_clear_ac, io_data_avail and io_data_out.
  - Result: ac_out = (clr ? 12'o0000 : io_data_in) | (avail ? data : 12'o0000). ac_load = clr|avail; skip = registered io_skip.
- io_select=0 (internal, no bus cycle; iot stays 0):
  - ir[2:0]=1 (ION, 6001): set ion_pending.
  - ir[2:0]=2 (IOF, 6002): clear ion and ion_pending.
  - ir[2:0]=0 (SKON, 6000): skip=ion, then clear ion and ion_pending.
  - Other ir[2:0]: no effect.
  - In all cases ac_load=0.
- ION delay: ion_pending transfers to ion on the first `instr_done` strictly after the cycle ION's own `done` was issued. The `instr_done` of the ION instruction itself does not transfer it.
- int_req = ion & io_interrupt_q, where io_interrupt_q is io_interrupt registered once. Both are registered, so int_req is a registered output.
- int_ack clears ion and ion_pending. If int_ack coincides with an ION/IOF/SKON update, int_ack wins.

## Timing
- Reset values: state=IDLE, iot=0, busy=0, done=0, ac_load=0, skip=0, ac_out=0, mb=0, io_select=0, io_data_in=0, ion=0, ion_pending=0, int_req=0.
- Device IOT: start sampled in cycle N; F0 in N+1, F1 in N+2, F2 in N+3, F3 in N+4; done/ac_out/ac_load/skip in N+5 for exactly one cycle; busy=0 in N+5.
- Internal IOT: done in N+1. ion/ion_pending take their new values in N+1.
- A start is accepted in the done cycle (N+5) or later. A start while busy is ignored.
- ac_out, ac_load and skip are zero except in the done cycle.
- Reset mid-sequence returns to IDLE next cycle: no done, iot=0, ion=0.
- int_req lags io_interrupt by 2 cycles when ion=1.

## Test plan
- Reset, then ir=6046 (TLS), ac_in=0o101 → io_select=0o04, mb=0o6046, io_data_in=0o101, iot=1 and state 1,2,3,4 over 4 cycles; done at N+5 with ac_load=0, skip=0.
- ir=6036 (KRB), ac_in=0o777; device drives clr=1, avail=1, data=0o215 in F2 → ac_out=0o215, ac_load=1.
- ir=6034 (KRS), ac_in=0o100; avail=1, data=0o215, clr=0 → ac_out=0o315; separately io_skip=1 in F2 only → skip=1 at done.
- ION (6001): done at N+1 with ion=0. Pulse instr_done for ION → ion stays 0. Next instr_done → ion=1. Hold io_interrupt=1 → int_req=1 two cycles later. int_ack → ion=0 and int_req=0.
- SKON with ion=1 → skip=1 and ion=0. IOF → ion=0. ION then IOF before the next instr_done → ion stays 0.
- start during F1 → ignored (exactly one done). Reset asserted in F2 → state=0, iot=0 next cycle, no done. Non-IOT ir=7200 with start → no response.
